// File: rtl/lcd_rst_sequencer_if.sv
// Avalon-MM slave bundle for the LCD reset sequencer: word address, write strobe
// and zero-wait-state read data.
interface lcd_rst_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lcd_rst_sequencer.sv
// Timed LCD panel reset: a minimum-width low pulse on lcd_rst_n, then a recovery wait,
// then READY with a done strobe and a maskable IRQ. Status and trigger are on a small Avalon slave.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no sequence has run since reset, lcd_rst_n high, not ready
//   ST_ASSERT  | panel held in reset until the minimum width passes and rst_req drops
//   ST_RECOVER | lcd_rst_n released, waiting out the panel recovery time
//   ST_READY   | panel usable, ready high
module lcd_rst_sequencer #(
  parameter int unsigned T_RST_LOW = 500000,
  parameter int unsigned T_RECOVER = 6000000,
  parameter bit          AUTO_POR  = 1'b1,
  parameter int unsigned CNT_W     = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rst_req,
  lcd_rst_sequencer_if.slave   avs,
  output logic                 lcd_rst_n,
  output logic                 ready,
  output logic                 done_pulse,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2,
    ST_READY   = 2'd3
  } state_t;

  // The timer counts the cycles still to go, so both phases end on a zero compare.
  localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(T_RST_LOW - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(T_RECOVER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;
  logic             rst_req_d;
  logic             bus_wr;
  logic             sw_trig;
  logic             trig;
  logic             irq_clr;
  logic             irq_flag;
  logic             irq_en;
  logic             unused_wd;

  assign bus_wr    = avs.chipselect & ~avs.write_n;
  assign sw_trig   = bus_wr & (avs.address == 2'd3) & avs.writedata[0];
  assign irq_clr   = bus_wr & (avs.address == 2'd1) & avs.writedata[0];
  assign trig      = (rst_req & ~rst_req_d) | sw_trig;
  assign unused_wd = ^avs.writedata[31:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= AUTO_POR ? ST_ASSERT : ST_IDLE;
      cnt_q   <= LOW_LOAD;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        state_nx = ST_IDLE;
      end
      ST_ASSERT: begin
        // Holds at zero while rst_req stays high, stretching the low pulse.
        if (cnt_q != '0) begin
          cnt_nx = cnt_q - CNT_ONE;
        end else if (!rst_req) begin
          state_nx = ST_RECOVER;
          cnt_nx   = REC_LOAD;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_nx = ST_READY;
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      ST_READY: begin
        state_nx = ST_READY;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    if (trig) begin
      state_nx = ST_ASSERT;
      cnt_nx   = LOW_LOAD;
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_rst_n  <= ~AUTO_POR;
      ready      <= 1'b0;
      done_pulse <= 1'b0;
      rst_req_d  <= 1'b0;
    end else begin
      lcd_rst_n  <= (state_nx != ST_ASSERT);
      ready      <= (state_nx == ST_READY);
      done_pulse <= (state_nx == ST_READY) && (state_q != ST_READY);
      rst_req_d  <= rst_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (done_pulse) begin
        irq_flag <= 1'b1;
      end else if (irq_clr) begin
        irq_flag <= 1'b0;
      end
      if (bus_wr && (avs.address == 2'd2)) begin
        irq_en <= avs.writedata[0];
      end
    end
  end

  assign irq = irq_flag & irq_en;

  always_comb begin
    avs.readdata = '0;
    unique case (avs.address)
      2'd0:    avs.readdata = {29'b0, state_q, ready};
      2'd1:    avs.readdata = {31'b0, irq_flag};
      2'd2:    avs.readdata = {31'b0, irq_en};
      default: avs.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lcd_rst_sequencer.sv
// Bench for lcd_rst_sequencer: an AUTO_POR=1 and an AUTO_POR=0 instance share stimulus and are
// compared every cycle against a timestamp-based model, plus hand-computed timing points.
module tb_lcd_rst_sequencer;
  localparam int T_RST_LOW = 4;
  localparam int T_RECOVER = 6;
  localparam int CNT_W     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rst_req;
  logic [1:0] lcd_w;
  logic [1:0] ready_w;
  logic [1:0] done_w;
  logic [1:0] irq_w;

  lcd_rst_sequencer_if bus0();
  lcd_rst_sequencer_if bus1();

  lcd_rst_sequencer #(.T_RST_LOW(T_RST_LOW), .T_RECOVER(T_RECOVER), .AUTO_POR(1'b1), .CNT_W(CNT_W)) u_dut_por (
    .clk(clk), .reset(reset), .rst_req(rst_req), .avs(bus0),
    .lcd_rst_n(lcd_w[0]), .ready(ready_w[0]), .done_pulse(done_w[0]), .irq(irq_w[0])
  );

  lcd_rst_sequencer #(.T_RST_LOW(T_RST_LOW), .T_RECOVER(T_RECOVER), .AUTO_POR(1'b0), .CNT_W(CNT_W)) u_dut_idle (
    .clk(clk), .reset(reset), .rst_req(rst_req), .avs(bus1),
    .lcd_rst_n(lcd_w[1]), .ready(ready_w[1]), .done_pulse(done_w[1]), .irq(irq_w[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit valid  = 1'b0;

  // Model: a sequence is described by the cycle its low pulse began and the cycle it was released.
  int   seq_start [2];
  int   rel       [2];
  logic flag      [2];
  logic en        [2];
  logic prev_rq   [2];

  logic        cur_rst;
  logic        cur_rq;
  logic [1:0]  cur_a;
  logic        cur_cs;
  logic        cur_wn;
  logic [31:0] cur_wd;

  function automatic int phase(int i);
    if (seq_start[i] < 0) return 0;
    if (rel[i] < 0) return 1;
    if (cyc - rel[i] < T_RECOVER) return 2;
    return 3;
  endfunction

  function automatic logic exp_done(int i);
    return (rel[i] >= 0) && (cyc - rel[i] == T_RECOVER);
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
    logic [1:0] ph;
    ph = 2'(phase(i));
    case (a)
      2'd0:    return {29'b0, ph, (ph == 2'd3)};
      2'd1:    return {31'b0, flag[i]};
      2'd2:    return {31'b0, en[i]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rq, input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd);
    cur_rst = r; cur_rq = rq; cur_a = a; cur_cs = cs; cur_wn = wn; cur_wd = wd;
    reset = r; rst_req = rq;
    bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
    bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
    #1;
  endtask

  task automatic model_update();
    logic wr, trig, done_now;
    wr = cur_cs && !cur_wn;
    for (int i = 0; i < 2; i++) begin
      if (cur_rst) begin
        seq_start[i] = (i == 0) ? cyc + 1 : -1;
        rel[i]       = -1;
        flag[i]      = 1'b0;
        en[i]        = 1'b0;
        prev_rq[i]   = 1'b0;
      end else begin
        trig     = (cur_rq && !prev_rq[i]) || (wr && cur_a == 2'd3 && cur_wd[0]);
        done_now = exp_done(i);
        if (done_now) flag[i] = 1'b1;
        else if (wr && cur_a == 2'd1 && cur_wd[0]) flag[i] = 1'b0;
        if (wr && cur_a == 2'd2) en[i] = cur_wd[0];
        if (trig) begin
          seq_start[i] = cyc + 1;
          rel[i]       = -1;
        end else if (phase(i) == 1 && cyc - seq_start[i] >= T_RST_LOW - 1 && !cur_rq) begin
          rel[i] = cyc + 1;
        end
        prev_rq[i] = cur_rq;
      end
    end
    if (cur_rst) valid = 1'b1;
  endtask

  task automatic advance();
    logic [31:0] rd;
    if (valid) begin
      for (int i = 0; i < 2; i++) begin
        rd = (i == 0) ? bus0.readdata : bus1.readdata;
        chk("lcd_rst_n", i, lcd_w[i], phase(i) != 1);
        chk("ready", i, ready_w[i], phase(i) == 3);
        chk("done_pulse", i, done_w[i], exp_done(i));
        chk("irq", i, irq_w[i], flag[i] & en[i]);
        chk("readdata", i, rd, exp_rd(i, cur_a));
      end
    end
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0);
      advance();
    end
  endtask

  initial begin
    int ndone;
    int ndone1;
    logic rq_s;
    #1;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0);
    advance();
    advance();

    // Power-on sequence, cycle 0 is the first cycle with reset low.
    for (int k = 0; k <= 12; k++) begin
      drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0);
      if (k <= 3) chk("por_low", 0, lcd_w[0], 1'b0);
      if (k == 4) chk("por_release", 0, lcd_w[0], 1'b1);
      if (k == 9) chk("por_not_ready", 0, ready_w[0], 1'b0);
      if (k == 10) begin
        chk("por_ready", 0, ready_w[0], 1'b1);
        chk("por_done", 0, done_w[0], 1'b1);
      end
      if (k == 11) begin
        chk("por_done_once", 0, done_w[0], 1'b0);
        chk("por_status", 0, bus0.readdata, 32'h7);
      end
      if (k == 5) begin
        chk("idle_por_lcd", 1, lcd_w[1], 1'b1);
        chk("idle_por_ready", 1, ready_w[1], 1'b0);
      end
      advance();
    end

    // Enable the IRQ and clear the flag left by power-on.
    drive(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h1);
    advance();
    drive(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h1);
    advance();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0);
    chk("irq_cleared", 0, irq_w[0], 1'b0);
    advance();

    // One-cycle rst_req from READY; clear attempted in the done cycle, then later.
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0);
    advance();
    for (int k = 1; k <= 14; k++) begin
      if (k == 11 || k == 13) drive(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h1);
      else drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0);
      if (k >= 1 && k <= 4) chk("pulse_low", 0, lcd_w[0], 1'b0);
      if (k == 5) chk("pulse_release", 0, lcd_w[0], 1'b1);
      if (k == 1) chk("pulse_ready_drop", 0, ready_w[0], 1'b0);
      if (k == 10) chk("pulse_ready_late", 0, ready_w[0], 1'b0);
      if (k == 11) begin
        chk("pulse_ready", 0, ready_w[0], 1'b1);
        chk("pulse_done", 0, done_w[0], 1'b1);
      end
      if (k == 12) chk("irq_set_wins", 0, irq_w[0], 1'b1);
      if (k == 14) chk("irq_clear", 0, irq_w[0], 1'b0);
      advance();
    end

    // rst_req held for ten cycles stretches the low pulse.
    for (int k = 0; k <= 11; k++) begin
      drive(1'b0, (k <= 9), 2'd0, 1'b0, 1'b1, 32'h0);
      if (k == 1) chk("hold_low_first", 0, lcd_w[0], 1'b0);
      if (k == 10) chk("hold_low_last", 0, lcd_w[0], 1'b0);
      if (k == 11) chk("hold_release", 0, lcd_w[0], 1'b1);
      advance();
    end
    idle(12);

    // Retrigger during RECOVER at its fourth cycle.
    ndone = 0;
    for (int k = 0; k <= 22; k++) begin
      drive(1'b0, (k == 0 || k == 8), 2'd0, 1'b0, 1'b1, 32'h0);
      if (done_w[0]) ndone++;
      if (k == 9 || k == 12) chk("retrig_low", 0, lcd_w[0], 1'b0);
      if (k == 13) chk("retrig_release", 0, lcd_w[0], 1'b1);
      if (k == 11) chk("retrig_no_done", 0, done_w[0], 1'b0);
      if (k == 19) chk("retrig_done", 0, done_w[0], 1'b1);
      advance();
    end
    chk("retrig_done_count", 0, ndone, 1);

    // Reset during ASSERT: one instance restarts, the other goes idle.
    ndone1 = 0;
    for (int k = 0; k <= 15; k++) begin
      drive((k == 2), (k == 0), 2'd0, 1'b0, 1'b1, 32'h0);
      if (done_w[1]) ndone1++;
      if (k == 3) begin
        chk("rst_mid_lcd_idle", 1, lcd_w[1], 1'b1);
        chk("rst_mid_ready_idle", 1, ready_w[1], 1'b0);
      end
      if (k == 6) chk("rst_mid_low", 0, lcd_w[0], 1'b0);
      if (k == 7) chk("rst_mid_release", 0, lcd_w[0], 1'b1);
      if (k == 13) chk("rst_mid_done", 0, done_w[0], 1'b1);
      if (k == 14) chk("rst_mid_status_idle", 1, bus1.readdata, 32'h0);
      advance();
    end
    chk("idle_no_done", 1, ndone1, 0);

    // Software trigger wakes the idle instance.
    drive(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 32'h1);
    advance();
    drive(1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 32'h0);
    chk("sw_trig_low", 1, lcd_w[1], 1'b0);
    chk("sw_trig_reads0", 1, bus1.readdata, 32'h0);
    advance();
    idle(12);

    // Randomised traffic.
    rq_s = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (rq_s) rq_s = ($urandom_range(0, 3) != 0);
      else rq_s = ($urandom_range(0, 29) == 0);
      drive(($urandom_range(0, 399) == 0), rq_s, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
